mem_access_unit: RTL
====================

# mem_access_unit

Parametrised memory-access and writeback stage of the RISC-V pipeline, between EX and the register file. Accepts one EX-stage operation at a time over a valid/ready handshake and drives a data-memory port with variable latency. Generates byte enables and lane-aligned write data for stores; extracts and sign/zero-extends load data by address offset. Flags misaligned accesses and presents one registered writeback beat per operation.

## Interface
- XLEN, 32, datapath width; 32 or 64 (64 enables LD/LWU/SD).
- ADDR_W, 32, byte-address width.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid / ex_ready  in / out  1  EX operation handshake; transfer when both high.
- ex_mem_rd, ex_mem_wr  in  1  load / store (never both high).
- ex_funct3  in  3  access size and signedness.
- ex_addr  in  ADDR_W  effective address.
- ex_wdata  in  XLEN  store data, right-justified.
- ex_rd_idx  in  5  destination register.
- ex_rd_src  in  1  non-memory result select: 0 = ex_alu_res, 1 = ex_pc4.
- ex_alu_res, ex_pc4  in  XLEN  candidate results.
- dmem_req_valid / dmem_req_ready  out / in  1  memory request handshake.
- dmem_we  out  1  write request.
- dmem_addr  out  ADDR_W  word-aligned address (low log2(XLEN/8) bits zero).
- dmem_be  out  XLEN/8  byte enables.
- dmem_wdata  out  XLEN  lane-shifted store data.
- dmem_rsp_valid  in  1  read data valid (loads only; stores get no response).
- dmem_rsp_data  in  XLEN  full-word read data.
- wb_valid  out  1  one-cycle writeback beat.
- wb_we  out  1  register write enable (0 for stores, rd=0, or faults).
- wb_rd_idx  out  5  destination register.
- wb_data  out  XLEN  writeback value.
- misalign_err  out  1  pulse with wb_valid for a misaligned access.
- misalign_addr  out  ADDR_W  faulting address, held until next fault.

## Operation
- funct3: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only); others illegal, treated as misaligned fault.
- Misaligned: H with addr[0]≠0, W with addr[1:0]≠0, D with addr[2:0]≠0. No memory request issued; wb_we=0, misalign_err=1.
- States: IDLE, REQ, WAIT, WB.
- IDLE: ex_ready=1. On transfer: non-memory or fault → WB; load/store → REQ (request fields registered).
- REQ: dmem_req_valid=1, fields stable until dmem_req_ready. Accepted load → WAIT; accepted store → WB.
- WAIT: on dmem_rsp_valid capture extracted data → WB.
- WB: wb_valid=1 for one cycle → IDLE.
- Load extract: shift dmem_rsp_data right by 8·offset, take size bits, sign-extend (B/H/W) or zero-extend (BU/HU/WU) to XLEN.
- Store: dmem_be = size mask << offset; dmem_wdata = ex_wdata << 8·offset.
- wb_data for stores and faults is 0; wb_we forced 0 when rd_idx=0.

## Timing
- Reset: state IDLE; all outputs 0 except ex_ready=1; misalign_addr=0.
- Non-memory/fault accepted at cycle N → wb_valid at N+1.
- Load accepted at N: request visible N+1; accepted at A≥N+1; response at R≥A+1 → wb_valid at R+1.
- Store accepted at N, request accepted at A → wb_valid at A+1.
- dmem_rsp_valid outside WAIT ignored. ex_ready=0 in all states but IDLE (one outstanding op).
- Reset mid-operation aborts instantly; a pending request is dropped, no wb_valid.

## Structure
- Package mau_pkg: funct3 localparams, rd_src encoding, state enum, size-mask function.
- One sub-module: load_extract (combinational align/extend, parametrised by XLEN).

## Test plan
- ALU op rd=5, alu_res=0x1234, accepted cycle 3 → wb_valid cycle 4, wb_data=0x1234, wb_we=1.
- LB addr=0x1003, rsp_data=0x80FF_FF00 → wb_data=0xFFFF_FF80; LBU → 0x0000_0080.
- SH addr=0x2002, wdata=0xABCD → dmem_be=4'b1100, dmem_wdata=0xABCD_0000, dmem_addr=0x2000, wb_we=0.
- LW addr=0x1001 → no dmem_req_valid, misalign_err=1, misalign_addr=0x1001, wb_we=0.
- dmem_req_ready low 4 cycles, rsp after 3 more → request fields stable throughout, one wb_valid pulse, ex_ready low until return to IDLE.
- rst asserted while in WAIT → outputs zero immediately, no wb_valid after release; XLEN=64 LWU addr=0x4 → upper word zero-extended.

Source files
------------

// File: rtl/mau_pkg.sv
// mau_pkg: shared funct3 codes, result-source encoding, FSM states and byte-mask helper
package mau_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  localparam logic RD_SRC_ALU = 1'b0;
  localparam logic RD_SRC_PC4 = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    return sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0f : 8'hff;
  endfunction
endpackage

// File: rtl/mem_access_unit_load_extract.sv
// load_extract: shifts a full-word read down by byte offset and sign/zero-extends to the access size
module load_extract
  import mau_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]               funct3,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [XLEN-1:0]          rsp_data,
  output logic [XLEN-1:0]          data
);
  logic [1:0] sz;
  logic [XLEN-1:0] shifted, keep;
  logic sgn, uns;
  always_comb begin
    sz = funct3[1:0];
    shifted = rsp_data >> {offset, 3'b000};
    keep = sz == F3_B[1:0] ? XLEN'(8'hff) : sz == F3_H[1:0] ? XLEN'(16'hffff) : sz == F3_W[1:0] ? XLEN'(32'hffff_ffff) : '1;
    sgn = sz == F3_B[1:0] ? shifted[7] : sz == F3_H[1:0] ? shifted[15] : sz == F3_W[1:0] ? shifted[31] : 1'b0;
    uns = funct3 == F3_BU || funct3 == F3_HU || funct3 == F3_WU;
    data = (shifted & keep) | ({XLEN{sgn & ~uns}} & ~keep);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: EX-to-writeback memory stage with one outstanding op, store lane alignment, load extraction and misalignment faults
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic                ex_mem_rd,
  input  logic                ex_mem_wr,
  input  logic [2:0]          ex_funct3,
  input  logic [ADDR_W-1:0]   ex_addr,
  input  logic [XLEN-1:0]     ex_wdata,
  input  logic [4:0]          ex_rd_idx,
  input  logic                ex_rd_src,
  input  logic [XLEN-1:0]     ex_alu_res,
  input  logic [XLEN-1:0]     ex_pc4,
  output logic                dmem_req_valid,
  input  logic                dmem_req_ready,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [XLEN/8-1:0]   dmem_be,
  output logic [XLEN-1:0]     dmem_wdata,
  input  logic                dmem_rsp_valid,
  input  logic [XLEN-1:0]     dmem_rsp_data,
  output logic                wb_valid,
  output logic                wb_we,
  output logic [4:0]          wb_rd_idx,
  output logic [XLEN-1:0]     wb_data,
  output logic                misalign_err,
  output logic [ADDR_W-1:0]   misalign_addr
);
  localparam int OFF_W = $clog2(XLEN/8);
  localparam int BEW = XLEN/8;
  state_t state;
  logic [2:0] ld_f3;
  logic [OFF_W-1:0] ld_off, off;
  logic [XLEN-1:0] ld_data;
  logic [1:0] sz;
  logic mem_op, legal, mis, fault;
  always_comb begin
    sz = ex_funct3[1:0];
    off = ex_addr[OFF_W-1:0];
    mem_op = ex_mem_rd | ex_mem_wr;
    legal = XLEN == 64 ? ex_funct3 != 3'b111 : ex_funct3 != F3_D && ex_funct3 != F3_WU && ex_funct3 != 3'b111;
    mis = sz == F3_H[1:0] ? ex_addr[0] : sz == F3_W[1:0] ? |ex_addr[1:0] : sz == F3_D[1:0] ? |ex_addr[2:0] : 1'b0;
    fault = mem_op & (~legal | mis);
  end
  load_extract #(.XLEN(XLEN)) u_extract (
    .funct3(ld_f3),
    .offset(ld_off),
    .rsp_data(dmem_rsp_data),
    .data(ld_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      ex_ready <= 1'b1;
      dmem_req_valid <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_be <= '0;
      dmem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_we <= 1'b0;
      wb_rd_idx <= '0;
      wb_data <= '0;
      misalign_err <= 1'b0;
      misalign_addr <= '0;
      ld_f3 <= '0;
      ld_off <= '0;
    end else case (state)
      S_IDLE: if (ex_valid && ex_ready) begin
        ex_ready <= 1'b0;
        wb_rd_idx <= ex_rd_idx;
        ld_f3 <= ex_funct3;
        ld_off <= off;
        if (mem_op && !fault) begin
          state <= S_REQ;
          dmem_req_valid <= 1'b1;
          dmem_we <= ex_mem_wr;
          dmem_addr <= {ex_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          dmem_be <= BEW'(size_mask(sz)) << off;
          dmem_wdata <= ex_wdata << {off, 3'b000};
        end else begin
          state <= S_WB;
          wb_valid <= 1'b1;
          wb_we <= !mem_op && ex_rd_idx != 5'd0;
          wb_data <= mem_op ? '0 : ex_rd_src == RD_SRC_PC4 ? ex_pc4 : ex_alu_res;
          misalign_err <= fault;
          if (fault) misalign_addr <= ex_addr;
        end
      end
      S_REQ: if (dmem_req_ready) begin
        dmem_req_valid <= 1'b0;
        dmem_we <= 1'b0;
        dmem_be <= '0;
        state <= dmem_we ? S_WB : S_WAIT;
        wb_valid <= dmem_we;
        wb_we <= 1'b0;
        wb_data <= '0;
      end
      S_WAIT: if (dmem_rsp_valid) begin
        state <= S_WB;
        wb_valid <= 1'b1;
        wb_we <= wb_rd_idx != 5'd0;
        wb_data <= ld_data;
      end
      S_WB: begin
        state <= S_IDLE;
        ex_ready <= 1'b1;
        wb_valid <= 1'b0;
        wb_we <= 1'b0;
        misalign_err <= 1'b0;
      end
    endcase
endmodule
